// File: rtl/fft_stage_sequencer.sv
// Issue/drain sequencer for an in-place radix-2 DIT FFT butterfly datapath.
// Optional macro FFT_SEQ_STALL_EN adds a stall input that pauses issue.
module fft_stage_sequencer #(
    parameter int N_LOG2       = 4,
    parameter int BFLY_LATENCY = 4,
    parameter int MEM_RD_LAT   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              bank_sel,
    output logic [N_LOG2-1:0] stage,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_y,
    output logic [N_LOG2-1:0] wr_addr_z
`ifdef FFT_SEQ_STALL_EN
    ,input logic              stall
`endif
);

    localparam int L  = MEM_RD_LAT + BFLY_LATENCY;
    localparam int AW = N_LOG2;
    localparam int KW = N_LOG2 - 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            hold;
    logic            pend;
    logic [AW-1:0]   is_s;
    logic [KW-1:0]   is_k;
    logic [L-1:0]    dv;
    logic [AW-1:0]   da [L];
    logic [AW-1:0]   db [L];

`ifdef FFT_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [AW-1:0] addr_a(
        input logic [AW-1:0] s,
        input logic [KW-1:0] kk
    );
        logic [AW-1:0] kx;
        logic [AW-1:0] mask;
        kx   = {1'b0, kk};
        mask = (AW'(1) << s) - AW'(1);
        return (((kx >> s) << s) << 1) | (kx & mask);
    endfunction

    function automatic logic [KW-1:0] tw_idx(
        input logic [AW-1:0] s,
        input logic [KW-1:0] kk
    );
        logic [KW-1:0] mask;
        logic [AW-1:0] sh;
        mask = (KW'(1) << s) - KW'(1);
        sh   = AW'(KW) - s;
        return (kk & mask) << sh;
    endfunction

    // Leaving DRAIN issues k=0 of the next stage in the same edge.
    always_comb begin
        is_s = stage;
        is_k = k;
        if (state == DRAIN) begin
            is_s = stage + AW'(1);
            is_k = '0;
        end
    end

    // The entry at the delay line tail is being written this cycle.
    always_comb begin
        pend = rd_en;
        for (int i = 0; i < L - 1; i++) begin
            pend = pend | dv[i];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            bank_sel  <= 1'b0;
            stage     <= '0;
            k         <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        stage    <= '0;
                        bank_sel <= 1'b0;
                        k        <= '0;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        rd_en     <= 1'b1;
                        rd_addr_a <= addr_a(is_s, is_k);
                        rd_addr_b <= addr_a(is_s, is_k)
                                   + (AW'(1) << is_s);
                        tw_addr   <= tw_idx(is_s, is_k);
                        k         <= k + KW'(1);
                        if (k == '1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        if (stage == AW'(N_LOG2 - 1)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            stage    <= is_s;
                            bank_sel <= ~bank_sel;
                            k        <= '0;
                            if (!hold) begin
                                rd_en     <= 1'b1;
                                rd_addr_a <= addr_a(is_s, is_k);
                                rd_addr_b <= addr_a(is_s, is_k)
                                           + (AW'(1) << is_s);
                                tw_addr   <= tw_idx(is_s, is_k);
                                k         <= KW'(1);
                            end
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dv <= '0;
            for (int i = 0; i < L; i++) begin
                da[i] <= '0;
                db[i] <= '0;
            end
        end else begin
            dv    <= {dv[L-2:0], rd_en};
            da[0] <= rd_addr_a;
            db[0] <= rd_addr_b;
            for (int i = 1; i < L; i++) begin
                da[i] <= da[i-1];
                db[i] <= db[i-1];
            end
        end
    end

    assign wr_en     = dv[L-1];
    assign wr_addr_y = da[L-1];
    assign wr_addr_z = db[L-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer (N_LOG2=4, latency 5).
module tb_fft_stage_sequencer;

    localparam int NL = 4;
    localparam int H  = 8;
    localparam int L  = 5;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, rd_en, bank_sel, wr_en;
    logic [3:0] rd_addr_a, rd_addr_b, stage;
    logic [3:0] wr_addr_y, wr_addr_z;
    logic [2:0] tw_addr;
`ifdef FFT_SEQ_STALL_EN
    logic       stall = 1'b0;
`endif

    fft_stage_sequencer #(
        .N_LOG2(4), .BFLY_LATENCY(4), .MEM_RD_LAT(1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .start(start),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .bank_sel(bank_sel),
        .stage(stage), .wr_en(wr_en),
        .wr_addr_y(wr_addr_y), .wr_addr_z(wr_addr_z)
`ifdef FFT_SEQ_STALL_EN
        , .stall(stall)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit en;
        int a, b, tw, s;
    } ev_t;

    typedef struct {
        int s, k, a, b, tw;
    } vec_t;

    ev_t erd [0:159];
    ev_t ewr [0:159];
    bit  stall_at [0:159];
    int  done_t;
    int  done_seen;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  rec = 0;
    int  obs_a [0:3][0:7];
    int  obs_b [0:3][0:7];
    int  obs_tw [0:3][0:7];
    int  obs_bank [0:3];
    int  cnt [0:3];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic clr_stall();
        for (int i = 0; i < 160; i++) stall_at[i] = 1'b0;
    endtask

    // Schedule from the addressing rules: one slot per unstalled cycle,
    // L-cycle write delay, next stage one cycle after last write.
    task automatic build();
        int t;
        t = 1;
        for (int i = 0; i < 160; i++) begin
            erd[i] = '{1'b0, 0, 0, 0, 0};
            ewr[i] = '{1'b0, 0, 0, 0, 0};
        end
        for (int s = 0; s < NL; s++) begin
            int half;
            half = 1 << s;
            for (int k = 0; k < H; k++) begin
                int j;
                while (stall_at[t]) t++;
                j = k % half;
                erd[t] = '{1'b1, (k / half) * 2 * half + j,
                           (k / half) * 2 * half + j + half,
                           j * (H / half), s};
                ewr[t + L] = erd[t];
                t++;
            end
            t += L;
        end
        done_t = t;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " rd_en"}, int'(rd_en), 0);
        chk({tag, " wr_en"}, int'(wr_en), 0);
        chk({tag, " bank_sel"}, int'(bank_sel), 0);
        chk({tag, " stage"}, int'(stage), 0);
        chk({tag, " rd_addr_a"}, int'(rd_addr_a), 0);
        chk({tag, " rd_addr_b"}, int'(rd_addr_b), 0);
        chk({tag, " tw_addr"}, int'(tw_addr), 0);
        chk({tag, " wr_addr_y"}, int'(wr_addr_y), 0);
        chk({tag, " wr_addr_z"}, int'(wr_addr_z), 0);
    endtask

    task automatic run_fft(input int pulse_at, input bit b2b);
        int nwr;
        nwr = 0;
        done_seen = -1;
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        build();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy after start", int'(busy), 1);
        chk("rd_en at c", int'(rd_en), 0);
        for (int t = 1; t <= done_t + 1; t++) begin
`ifdef FFT_SEQ_STALL_EN
            stall = stall_at[t];
`endif
            start = (t == pulse_at) || (b2b && t == done_t + 1);
            tick();
            chk("rd_en", int'(rd_en), int'(erd[t].en));
            if (erd[t].en) begin
                chk("rd_addr_a", int'(rd_addr_a), erd[t].a);
                chk("rd_addr_b", int'(rd_addr_b), erd[t].b);
                chk("tw_addr", int'(tw_addr), erd[t].tw);
                chk("stage", int'(stage), erd[t].s);
                chk("bank_sel", int'(bank_sel), erd[t].s % 2);
                if (rec && cnt[erd[t].s] < H) begin
                    obs_a[erd[t].s][cnt[erd[t].s]] = int'(rd_addr_a);
                    obs_b[erd[t].s][cnt[erd[t].s]] = int'(rd_addr_b);
                    obs_tw[erd[t].s][cnt[erd[t].s]] = int'(tw_addr);
                    if (cnt[erd[t].s] == 0)
                        obs_bank[erd[t].s] = int'(bank_sel);
                    cnt[erd[t].s]++;
                end
            end
            chk("wr_en", int'(wr_en), int'(ewr[t].en));
            if (wr_en) nwr++;
            if (ewr[t].en) begin
                chk("wr_addr_y", int'(wr_addr_y), ewr[t].a);
                chk("wr_addr_z", int'(wr_addr_z), ewr[t].b);
            end
            chk("done", int'(done), int'(t == done_t));
            chk("busy", int'(busy), int'(t <= done_t));
            if (done && done_seen < 0) done_seen = t;
        end
`ifdef FFT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        chk("write count", nwr, 32);
    endtask

    task automatic reset_mid(input int at);
        clr_stall();
        build();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= at; t++) tick();
        #2;
        Rst = 1'b1;
        #1;
        chk_zero("async rst");
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post-rst wr_en", int'(wr_en), 0);
            chk("post-rst rd_en", int'(rd_en), 0);
            chk("post-rst busy", int'(busy), 0);
        end
    endtask

    vec_t tbl [8];

    initial begin
        tbl = '{
            '{0, 0, 0, 1, 0},   '{0, 3, 6, 7, 0},
            '{1, 1, 1, 3, 4},   '{2, 5, 9, 13, 2},
            '{3, 5, 5, 13, 5},  '{1, 7, 13, 15, 4},
            '{2, 7, 11, 15, 6}, '{3, 7, 7, 15, 7}
        };
        clr_stall();
        #1 Rst = 1'b1;
        #2;
        chk_zero("reset");
        tick();
        tick();
        Rst = 1'b0;
        tick();
        chk_zero("idle");

        rec = 1'b1;
        run_fft(20, 1'b1);
        rec = 1'b0;
        chk("done cycle", done_seen, 53);
        foreach (tbl[i]) begin
            chk($sformatf("tbl%0d a", i),
                obs_a[tbl[i].s][tbl[i].k], tbl[i].a);
            chk($sformatf("tbl%0d b", i),
                obs_b[tbl[i].s][tbl[i].k], tbl[i].b);
            chk($sformatf("tbl%0d tw", i),
                obs_tw[tbl[i].s][tbl[i].k], tbl[i].tw);
        end
        for (int s = 0; s < 4; s++)
            chk($sformatf("bank stage%0d", s), obs_bank[s], s % 2);

        run_fft(0, 1'b0);
        chk("b2b done cycle", done_seen, 53);

        reset_mid(30);
        run_fft(0, 1'b0);
        chk("post-rst done cycle", done_seen, 53);

`ifdef FFT_SEQ_STALL_EN
        clr_stall();
        for (int t = 18; t <= 20; t++) stall_at[t] = 1'b1;
        rec = 1'b1;
        run_fft(0, 1'b0);
        rec = 1'b0;
        chk("stall done cycle", done_seen, 56);
        chk("stall resume a", obs_a[1][4], 8);
        chk("stall resume b", obs_b[1][4], 10);
        clr_stall();
`endif

        for (int it = 0; it < 6; it++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap busy", int'(busy), 0);
            end
            clr_stall();
            if ($urandom_range(0, 3) == 0) begin
                reset_mid(int'($urandom_range(2, 50)));
            end else begin
`ifdef FFT_SEQ_STALL_EN
                for (int t = 1; t < 60; t++)
                    stall_at[t] = ($urandom_range(0, 6) == 0);
`endif
                run_fft(int'($urandom_range(0, 50)), 1'b0);
            end
        end
        clr_stall();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences the radix-2 butterfly datapath (MultiplyAddUnit) through all log2(N) stages of an in-place DIT FFT.
- Generates ping-pong sample-memory read/write addresses and twiddle ROM indices, and tracks butterfly pipeline latency.
- Drains the pipeline between stages and reports completion.
- Sits between the top-level FFT control and the sample RAM banks, twiddle ROM and butterfly unit; input samples are pre-stored in bit-reversed order.

Parameters:
- N_LOG2, 4, log2 of FFT size (N=16); address width = N_LOG2
- BFLY_LATENCY, 4, butterfly cycles from A/B/w valid to Y/Z valid
- MEM_RD_LAT, 1, sample RAM / twiddle ROM read latency in cycles

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous reset, active-high
- start  input  1  begin FFT; sampled only in IDLE
- busy  output  1  high from cycle after start accepted until done pulse inclusive
- done  output  1  one-cycle pulse, FFT complete
- rd_en  output  1  read strobe to both sample banks and twiddle ROM
- rd_addr_a  output  N_LOG2  upper butterfly input address
- rd_addr_b  output  N_LOG2  lower butterfly input address
- tw_addr  output  N_LOG2-1  twiddle ROM index k for W_N^k
- bank_sel  output  1  read bank; writes go to ~bank_sel
- stage  output  N_LOG2  current stage index 0..N_LOG2-1
- wr_en  output  1  write strobe for Y/Z results
- wr_addr_y  output  N_LOG2  destination of Y (A+Bw)
- wr_addr_z  output  N_LOG2  destination of Z (A-Bw)

Behaviour:
- Reset: Rst high forces IDLE immediately. All outputs are 0, counters cleared, delay line flushed (valid bits 0). Rst mid-FFT aborts with no further wr_en.
- FSM IDLE -> ISSUE on start==1. ISSUE -> DRAIN after issuing butterfly k=N/2-1. DRAIN -> ISSUE (stage+1, bank_sel toggled) on the cycle after the last wr_en of the stage, if stage<N_LOG2-1. DRAIN -> DONE otherwise. DONE -> IDLE after one cycle, with done=1 for that cycle.
- start while not IDLE is ignored.
- ISSUE: one butterfly per cycle, rd_en=1, k counts 0..N/2-1. First rd_en is in the cycle after start is sampled.
- Addressing, for stage s, half=2^s, group=k>>s, j=k&(half-1):
  - rd_addr_a = group*2*half + j
  - rd_addr_b = rd_addr_a + half
  - tw_addr = j << (N_LOG2-1-s)
- All issue outputs are registered.
- Delay line of depth L=MEM_RD_LAT+BFLY_LATENCY carries valid, addr_a and addr_b. wr_en, wr_addr_y and wr_addr_z equal the rd_en, rd_addr_a and rd_addr_b values from exactly L cycles earlier.
- Stage timing: N/2 issue cycles, then L drain cycles. The next stage's first rd_en follows the previous stage's last wr_en by one cycle.
- No read of a bank is issued while writes to that bank are pending.
- Total for N=16, L=5: first rd_en at cycle c+1 (start sampled at c); last wr_en at c+52; done at c+53.
- busy=0 and all strobes 0 in IDLE. Address outputs hold their last value when strobes are low.
- bank_sel is 0 at start of each FFT. Final results reside in bank ~bank_sel(final stage), i.e. bank 0 when N_LOG2 is even.

Optional Feature:
- Macro: FFT_SEQ_STALL_EN.
- When defined: adds input stall (1 bit).
  - While stall=1 in ISSUE, rd_en=0 and k holds.
  - The delay line keeps shifting, so in-flight butterflies still complete and wr_en still occurs.
  - A bubble enters the delay line each stalled cycle.
  - Drain completes only when the delay line has no valid entries.
  - stall is ignored outside ISSUE.
- When undefined: no stall port; issue is never interrupted.

Test Plan:
- Reset then single start with N_LOG2=4 -> rd_en first at c+1. Stage 0 k=0: a=0, b=1, tw=0. k=3: a=6, b=7, tw=0.
- Address check:
  - stage 1 k=1 -> a=1, b=3, tw=4
  - stage 2 k=5 -> a=9, b=13, tw=2
  - stage 3 k=5 -> a=5, b=13, tw=5
  - bank_sel = 0, 1, 0, 1 per stage
- Latency check -> every wr_en and wr_addr pair matches the rd_en and rd_addr pair from 5 cycles earlier. 32 writes total. done is a single pulse at c+53 with busy falling after it.
- start pulsed during busy, and again back-to-back right after done -> first start ignored; second FFT runs identically with bank_sel restarting at 0.
- Rst asserted at stage 2 k=3 -> outputs 0 asynchronously, no wr_en after Rst. A clean run starts on the next start.
- FFT_SEQ_STALL_EN defined, stall=1 for 3 cycles at stage 1 k=4 -> rd_en low 3 cycles, k resumes at 4, done delayed to c+56, no missing or duplicate writes.
